// File: rtl/mc_pkg.sv
// mc_pkg: shared opcodes, state encodings, datapath select codes and trap causes
package mc_pkg;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_RWB    = 4'd7,
      S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
      S_TRAP   = 4'd12
   } state_t;
   localparam logic [1:0] ALU_ADD     = 2'b00;
   localparam logic [1:0] ALU_SUB     = 2'b01;
   localparam logic [1:0] ALU_FUNCT   = 2'b10;
   localparam logic [1:0] SRCB_RT     = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;
   localparam logic [1:0] PCS_ALU     = 2'b00;
   localparam logic [1:0] PCS_ALUOUT  = 2'b01;
   localparam logic [1:0] PCS_JUMP    = 2'b10;
   localparam logic [1:0] PCS_EXC     = 2'b11;
   typedef enum logic [1:0] {
      EXC_NONE = 2'b00, EXC_ILLEGAL = 2'b01, EXC_OVF = 2'b10, EXC_TIMEOUT = 2'b11
   } exc_t;
endpackage

// File: rtl/mc_mem_timer.sv
// mc_mem_timer: counts consecutive not-ready cycles of a memory handshake and flags a timeout
module mc_mem_timer #(
   parameter int MEM_WAIT_MAX = 15,
   parameter int CNT_W        = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic busy,
   input  logic mem_ready,
   output logic timeout
);
   logic [CNT_W-1:0] wait_cnt;
   assign timeout = busy && !mem_ready && wait_cnt == CNT_W'(MEM_WAIT_MAX);
   // every exit from a waiting state is caused by ready or timeout, so clearing on those covers state changes
   always_ff @(posedge clk)
      if (!rst_n || !busy || mem_ready || timeout) wait_cnt <= '0;
      else wait_cnt <= wait_cnt + CNT_W'(1);
endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle MIPS control sequencer with memory-wait timeout and trap reporting
module mc_control_fsm
   import mc_pkg::*;
#(
   parameter int MEM_WAIT_MAX = 15,
   parameter int CNT_W        = 8
) (
   input  logic       SYS_clk,
   input  logic       SYS_reset,
   input  logic [5:0] OpCode,
   input  logic       mem_ready,
   input  logic       alu_ovf,
   input  logic       alu_zero,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSource,
   output logic [3:0] state_o,
   output logic       retire,
   output logic       exc_valid,
   output logic [1:0] exc_cause
);
   state_t state;
   exc_t   pend_cause;
   logic   busy, timeout, unused_zero;
   // the branch decision itself is made in the datapath by gating PCWriteCond with alu_zero
   assign unused_zero = alu_zero;
   assign busy = state == S_FETCH || state == S_MEMRD || state == S_MEMWR;
   assign state_o = SYS_reset ? state : S_FETCH;
   mc_mem_timer #(.MEM_WAIT_MAX(MEM_WAIT_MAX), .CNT_W(CNT_W)) u_timer (
      .clk(SYS_clk), .rst_n(SYS_reset), .busy(busy), .mem_ready(mem_ready), .timeout(timeout)
   );
   always_ff @(posedge SYS_clk)
      if (!SYS_reset) begin
         state      <= S_FETCH;
         pend_cause <= EXC_NONE;
         exc_valid  <= 1'b0;
         exc_cause  <= EXC_NONE;
      end else
         case (state)
            S_FETCH, S_MEMRD, S_MEMWR:
               if (mem_ready) state <= state == S_FETCH ? S_DECODE : state == S_MEMRD ? S_MEMWB : S_FETCH;
               else if (timeout) begin
                  state      <= S_TRAP;
                  pend_cause <= EXC_TIMEOUT;
               end
            S_DECODE:
               case (OpCode)
                  OP_RTYPE:     state <= S_EXEC;
                  OP_LW, OP_SW: state <= S_MEMADR;
                  OP_BEQ:       state <= S_BRANCH;
                  OP_J:         state <= S_JUMP;
                  OP_ADDI:      state <= S_ADDIEX;
                  default: begin
                     state      <= S_TRAP;
                     pend_cause <= EXC_ILLEGAL;
                  end
               endcase
            S_MEMADR: state <= OpCode == OP_LW ? S_MEMRD : S_MEMWR;
            S_EXEC:   state <= S_RWB;
            S_ADDIEX: state <= S_ADDIWB;
            S_RWB, S_ADDIWB:
               if (alu_ovf) begin
                  state      <= S_TRAP;
                  pend_cause <= EXC_OVF;
               end else state <= S_FETCH;
            S_TRAP: begin
               state     <= S_FETCH;
               exc_valid <= 1'b1;
               exc_cause <= pend_cause;
            end
            default: state <= S_FETCH;
         endcase
   // strobes stay low while reset is held so an aborted instruction never commits
   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = SRCB_RT;
      ALUOp       = ALU_ADD;
      PCSource    = PCS_ALU;
      retire      = 1'b0;
      if (SYS_reset)
         case (state)
            S_FETCH: begin
               MemRead = !timeout;
               ALUSrcB = SRCB_FOUR;
               IRWrite = mem_ready;
               PCWrite = mem_ready;
            end
            S_DECODE: ALUSrcB = SRCB_IMM_SH;
            S_MEMADR, S_ADDIEX: begin
               ALUSrcA = 1'b1;
               ALUSrcB = SRCB_IMM;
            end
            S_MEMRD: begin
               MemRead = !timeout;
               IorD    = 1'b1;
            end
            S_MEMWB: begin
               RegWrite = 1'b1;
               MemtoReg = 1'b1;
               retire   = 1'b1;
            end
            S_MEMWR: begin
               MemWrite = !timeout;
               IorD     = 1'b1;
               retire   = mem_ready;
            end
            S_EXEC: begin
               ALUSrcA = 1'b1;
               ALUOp   = ALU_FUNCT;
            end
            S_RWB, S_ADDIWB: begin
               RegDst   = state == S_RWB;
               RegWrite = !alu_ovf;
               retire   = !alu_ovf;
            end
            S_BRANCH: begin
               ALUSrcA     = 1'b1;
               ALUOp       = ALU_SUB;
               PCWriteCond = 1'b1;
               PCSource    = PCS_ALUOUT;
               retire      = 1'b1;
            end
            S_JUMP: begin
               PCWrite  = 1'b1;
               PCSource = PCS_JUMP;
               retire   = 1'b1;
            end
            S_TRAP: begin
               PCWrite  = 1'b1;
               PCSource = PCS_EXC;
            end
            default: ;
         endcase
   end
endmodule
